detector_passagem: RTL and testbench

Two-beam vehicle passage detector for one parking gate lane. It synchronizes and debounces two raw photo-beam sensors (A = street side, B = lot side) and tracks the order in which they are blocked and cleared. It emits one-cycle `entrada`/`saida` pulses that drive the entry/exit requests of the gate/occupancy controller directly downstream. Partial, aborted or illegal crossings produce no count.

---
 rtl/passagem_pkg.sv | 15 +
 rtl/filtro_sensor.sv | 33 +++
 rtl/detector_passagem.sv | 107 ++++++++++
 tb/tb_detector_passagem.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/passagem_pkg.sv
// passagem_pkg: shared state encoding and default parameters for the two-beam passage detector.
package passagem_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        A1         = 3'd1,
        AB_A       = 3'd2,
        B_A        = 3'd3,
        B1         = 3'd4,
        AB_B       = 3'd5,
        A_B        = 3'd6,
        WAIT_CLEAR = 3'd7
    } estado_passagem_t;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 1000;
endpackage

// File: rtl/filtro_sensor.sv
// filtro_sensor: 2-flop synchronizer plus debouncer for one raw photo-beam.
module filtro_sensor #(
    parameter int DEBOUNCE_CYCLES = passagem_pkg::DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic sensor,
    output logic filtrado
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_filt;
    // r_cnt counts consecutive edges where the synchronized sample disagrees with r_filt
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], sensor};
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_filt <= ~r_filt;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign filtrado = r_filt;
endmodule

// File: rtl/detector_passagem.sv
// detector_passagem: two-beam gate-lane passage FSM emitting entrada/saida/erro pulses.
// Optional crossing timeout enabled by defining PASSAGE_TIMEOUT_EN.
module detector_passagem
    import passagem_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk_2,
    input  logic       reset_n,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic       entrada,
    output logic       saida,
    output logic       ocupado,
    output logic       erro,
    output logic [2:0] estado
);
    logic             w_a, w_b;
    logic [1:0]       w_ab;
    estado_passagem_t r_estado, w_prox, w_prox_f;
    logic             w_ent, w_sai, w_ilegal, w_tmo;
    logic             r_ent, r_sai, r_err, r_ocu;

    filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_a (
        .clk_2(clk_2), .reset_n(reset_n), .sensor(sensor_a), .filtrado(w_a)
    );
    filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_b (
        .clk_2(clk_2), .reset_n(reset_n), .sensor(sensor_b), .filtrado(w_b)
    );

    assign w_ab = {w_a, w_b};

    always_comb begin
        w_prox   = r_estado;
        w_ent    = 1'b0;
        w_sai    = 1'b0;
        w_ilegal = 1'b0;
        case (r_estado)
            IDLE: begin
                w_prox   = w_ab == 2'b10 ? A1 : w_ab == 2'b01 ? B1 : IDLE;
                w_ilegal = w_ab == 2'b11;
            end
            A1:   w_prox = w_ab == 2'b11 ? AB_A : w_ab == 2'b01 ? B_A : w_ab == 2'b00 ? IDLE : A1;
            AB_A: begin
                w_prox   = w_ab == 2'b01 ? B_A : w_ab == 2'b10 ? A1 : AB_A;
                w_ilegal = w_ab == 2'b00;
            end
            B_A: begin
                w_prox   = w_ab == 2'b00 ? IDLE : w_ab == 2'b11 ? AB_A : B_A;
                w_ent    = w_ab == 2'b00;
                w_ilegal = w_ab == 2'b10;
            end
            B1:   w_prox = w_ab == 2'b11 ? AB_B : w_ab == 2'b10 ? A_B : w_ab == 2'b00 ? IDLE : B1;
            AB_B: begin
                w_prox   = w_ab == 2'b10 ? A_B : w_ab == 2'b01 ? B1 : AB_B;
                w_ilegal = w_ab == 2'b00;
            end
            A_B: begin
                w_prox   = w_ab == 2'b00 ? IDLE : w_ab == 2'b11 ? AB_B : A_B;
                w_sai    = w_ab == 2'b00;
                w_ilegal = w_ab == 2'b01;
            end
            WAIT_CLEAR: w_prox = w_ab == 2'b00 ? IDLE : WAIT_CLEAR;
            default: ;
        endcase
    end

`ifdef PASSAGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          w_conta;
    // Counts edges spent in the current crossing state; fires on the edge that would reach the limit
    assign w_conta = r_estado != IDLE && r_estado != WAIT_CLEAR;
    assign w_tmo   = w_conta && w_prox == r_estado && r_tmo == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) r_tmo <= '0;
        else          r_tmo <= (!w_conta || w_prox_f != r_estado) ? '0 : r_tmo + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    assign w_prox_f = (w_ilegal || w_tmo) ? WAIT_CLEAR : w_prox;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= IDLE;
            r_ent    <= 1'b0;
            r_sai    <= 1'b0;
            r_err    <= 1'b0;
            r_ocu    <= 1'b0;
        end else begin
            r_estado <= w_prox_f;
            r_ent    <= w_ent;
            r_sai    <= w_sai;
            r_err    <= w_ilegal | w_tmo;
            r_ocu    <= w_a | w_b;
        end
    end

    assign entrada = r_ent;
    assign saida   = r_sai;
    assign erro    = r_err;
    assign ocupado = r_ocu;
    assign estado  = r_estado;
endmodule

// File: tb/tb_detector_passagem.sv
// tb_detector_passagem: random and directed stimulus checked each cycle against a table-driven model.
module tb_detector_passagem;
    localparam int DB  = 4;
    localparam int TMO = 20;

    logic       clk_2 = 1'b0, reset_n = 1'b0, sensor_a = 1'b0, sensor_b = 1'b0;
    logic       entrada, saida, ocupado, erro;
    logic [2:0] estado;

    detector_passagem #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_2(clk_2), .reset_n(reset_n), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .entrada(entrada), .saida(saida), .ocupado(ocupado), .erro(erro), .estado(estado)
    );

    always #5 clk_2 = ~clk_2;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    // next state per [state][{a,b}], -1 = illegal move
    int tbl [8][4] = '{'{0, 4, 1, -1}, '{0, 3, 1, 2}, '{-1, 3, 1, 2}, '{0, 3, -1, 2},
                       '{0, 4, 6, 5}, '{-1, 4, 6, 5}, '{0, -1, 6, 5}, '{0, 7, 7, 7}};
    int sa0, sa1, sb0, sb1, fa, fb, run_a, run_b, m_st, m_tmo;
    int m_ent, m_sai, m_err, m_ocu;
    int m_n_ent, m_n_sai, m_n_err, d_n_ent, d_n_sai, d_n_err;
    int d_last_ent, d_last_err, d_a1_cyc, prev_est, d_any;
    int trace[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // model step at every rising edge, then compare just after the edge
    initial forever begin
        @(posedge clk_2);
        cyc++;
        if (!reset_n) begin
            {sa0, sa1, sb0, sb1, fa, fb, run_a, run_b, m_st, m_tmo} = '0;
            {m_ent, m_sai, m_err, m_ocu} = '0;
        end else begin
            int p, t, nst;
            p     = fa * 2 + fb;
            t     = tbl[m_st][p];
            m_ent = int'(m_st == 3 && p == 0);
            m_sai = int'(m_st == 6 && p == 0);
            m_err = int'(t < 0);
            nst   = t < 0 ? 7 : t;
`ifdef PASSAGE_TIMEOUT_EN
            if (nst == m_st && m_st != 0 && m_st != 7) begin
                if (m_tmo == TMO - 1) begin
                    m_err = 1;
                    nst   = 7;
                    m_tmo = 0;
                end else m_tmo++;
            end else m_tmo = 0;
`endif
            m_ocu = fa | fb;
            m_st  = nst;
            run_a = sa1 != fa ? run_a + 1 : 0;
            run_b = sb1 != fb ? run_b + 1 : 0;
            if (run_a == DB) begin fa ^= 1; run_a = 0; end
            if (run_b == DB) begin fb ^= 1; run_b = 0; end
            sa1 = sa0; sa0 = int'(sensor_a);
            sb1 = sb0; sb0 = int'(sensor_b);
            m_n_ent += m_ent; m_n_sai += m_sai; m_n_err += m_err;
        end
        #1;
        chk("entrada", entrada, m_ent[7:0]);
        chk("saida",   saida,   m_sai[7:0]);
        chk("erro",    erro,    m_err[7:0]);
        chk("ocupado", ocupado, m_ocu[7:0]);
        chk("estado",  estado,  m_st[7:0]);
        if (entrada) begin d_n_ent++; d_last_ent = cyc; end
        if (saida) d_n_sai++;
        if (erro) begin d_n_err++; d_last_err = cyc; end
        if (ocupado || estado != 0) d_any = 1;
        if (int'(estado) != prev_est) begin
            trace.push_back(int'(estado));
            if (estado == 3'd1) d_a1_cyc = cyc;
            prev_est = int'(estado);
        end
    end

    task automatic hold(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        repeat (n) @(negedge clk_2);
    endtask

    initial begin
        int e0, s0, r0, me0, clr;
        repeat (3) @(negedge clk_2);
        chk("rst_entrada", entrada, 0);
        chk("rst_saida", saida, 0);
        chk("rst_erro", erro, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_estado", estado, 0);
        reset_n = 1'b1;
        hold(0, 0, 3);

        // clean entry
        e0 = d_n_ent; s0 = d_n_sai; r0 = d_n_err; me0 = m_n_ent;
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        clr = cyc + 1;
        hold(0, 0, 10);
        chk("entry_count", 8'(d_n_ent - e0), 1);
        chk("entry_model", 8'(m_n_ent - me0), 1);
        chk("entry_latency", 8'(d_last_ent - clr), 6);
        chk("entry_no_exit", 8'(d_n_sai - s0), 0);
        chk("entry_no_err", 8'(d_n_err - r0), 0);

        // clean exit with state trace
        trace.delete();
        s0 = d_n_sai;
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
        chk("exit_count", 8'(d_n_sai - s0), 1);
        chk("exit_trace_len", 8'(trace.size()), 4);
        if (trace.size() == 4) begin
            chk("exit_trace0", 8'(trace[0]), 4);
            chk("exit_trace1", 8'(trace[1]), 5);
            chk("exit_trace2", 8'(trace[2]), 6);
            chk("exit_trace3", 8'(trace[3]), 0);
        end

        // glitches shorter than the debounce window
        d_any = 0;
        for (int i = 0; i < 5; i++) begin hold(1, 0, 3); hold(0, 0, 5); end
        chk("glitch_quiet", 8'(d_any), 0);

        // abort back to idle
        e0 = d_n_ent; s0 = d_n_sai; r0 = d_n_err;
        hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
        chk("abort_pulses", 8'((d_n_ent - e0) + (d_n_sai - s0) + (d_n_err - r0)), 0);
        chk("abort_state", estado, 0);

        // backtrack then complete
        e0 = d_n_ent;
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
        chk("backtrack_count", 8'(d_n_ent - e0), 1);

        // illegal simultaneous start
        e0 = d_n_ent; s0 = d_n_sai; r0 = d_n_err;
        hold(1, 1, 10);
        chk("illegal_err", 8'(d_n_err - r0), 1);
        chk("illegal_wait", estado, 7);
        hold(0, 0, 10);
        chk("illegal_idle", estado, 0);
        chk("illegal_nocount", 8'((d_n_ent - e0) + (d_n_sai - s0)), 0);

`ifdef PASSAGE_TIMEOUT_EN
        r0 = d_n_err;
        hold(1, 0, 50);
        chk("timeout_err", 8'(d_n_err - r0), 1);
        chk("timeout_delay", 8'(d_last_err - d_a1_cyc), 8'(TMO));
        chk("timeout_wait", estado, 7);
        hold(0, 0, 10);
`endif

        // asynchronous reset in the middle of AB_A
        hold(1, 0, 10); hold(1, 1, 10);
        chk("mid_ab_a", estado, 2);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_estado", estado, 0);
        chk("arst_ocupado", ocupado, 0);
        chk("arst_pulses", {5'd0, entrada, saida, erro}, 0);
        @(negedge clk_2);
        r0 = d_n_err;
        reset_n = 1'b1;
        hold(1, 1, 15);
        chk("post_rst_err", 8'(d_n_err - r0), 1);
        chk("post_rst_wait", estado, 7);
        hold(0, 0, 10);

        // randomized segments with occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                @(negedge clk_2);
                reset_n = 1'b1;
            end
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        end
        hold(0, 0, 30);
        chk("final_idle", estado, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
